// File: rtl/vec_mul_pkg.sv
// Shared types for the vec_mul arbiter slice.
// Lock FSM states, stat counter width, pointer wrap helper.
package vec_mul_pkg;

  typedef enum logic {
    IDLE   = 1'b0,
    LOCKED = 1'b1
  } arb_state_t;

  localparam int STAT_W = 16;

  function automatic int wrap_inc(int i, int n);
    return (i + 1 >= n) ? 0 : i + 1;
  endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin pick: first set request
// at or above the pointer, wrapping around.
module rr_arbiter #(
  parameter int NUM_REQ = 4,
  parameter int ID_W    = 2
) (
  input  logic [NUM_REQ-1:0] req_i,
  input  logic [ID_W-1:0]    ptr_i,
  output logic [NUM_REQ-1:0] gnt_o,
  output logic [ID_W-1:0]    idx_o,
  output logic               any_o
);

  // scan requests starting at the pointer, wrapping once
  always_comb begin
    int j;
    logic [ID_W-1:0] jj;
    gnt_o = '0;
    idx_o = '0;
    any_o = 1'b0;
    j     = 0;
    jj    = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      j = int'(ptr_i) + k;
      if (j >= NUM_REQ) j = j - NUM_REQ;
      jj = ID_W'(j);
      if (!any_o && req_i[jj]) begin
        any_o     = 1'b1;
        idx_o     = jj;
        gnt_o[jj] = 1'b1;
      end
    end
  end

endmodule

// File: rtl/vec_mul_arb.sv
// Packet-locked round-robin arbiter in front of vec_mul.
// Optional VEC_MUL_ARB_STATS_EN adds packet/stall counters.
module vec_mul_arb
  import vec_mul_pkg::*;
#(
  parameter int NUM_REQ    = 4,
  parameter int I_BW       = 8,
  parameter int VECTOR_LEN = 13,
  parameter int ID_W       = $clog2(NUM_REQ)
) (
  input  logic                               clk_i,
  input  logic                               rst_n_i,
  input  logic [NUM_REQ*VECTOR_LEN*I_BW-1:0] req_data0_i,
  input  logic [NUM_REQ*VECTOR_LEN*I_BW-1:0] req_data1_i,
  input  logic [NUM_REQ-1:0]                 req_valid_i,
  input  logic [NUM_REQ-1:0]                 req_last_i,
  output logic [NUM_REQ-1:0]                 req_ready_o,
  output logic [VECTOR_LEN*I_BW-1:0]         mul_data0_o,
  output logic [VECTOR_LEN*I_BW-1:0]         mul_data1_o,
  output logic                               mul_valid_o,
  output logic                               mul_last_o,
  input  logic                               mul_ready_i,
  output logic [ID_W-1:0]                    mul_id_o
`ifdef VEC_MUL_ARB_STATS_EN
  ,
  output logic [NUM_REQ*STAT_W-1:0]          stat_pkts_o,
  output logic [STAT_W-1:0]                  stat_stall_o
`endif
);

  localparam int VW = VECTOR_LEN * I_BW;

  arb_state_t         state;
  logic [ID_W-1:0]    owner;
  logic [ID_W-1:0]    rr_ptr;
  logic [ID_W-1:0]    nxt_ptr;

  logic [NUM_REQ-1:0] arb_gnt;
  logic [ID_W-1:0]    arb_idx;
  logic               arb_any;

  logic [NUM_REQ-1:0] own_oh;
  logic [NUM_REQ-1:0] grant;
  logic [ID_W-1:0]    sel_idx;
  logic               locked;
  logic               sel_valid;
  logic               sel_last;
  logic [VW-1:0]      sel_d0;
  logic [VW-1:0]      sel_d1;
  logic               load_ok;
  logic               accept;

  rr_arbiter #(
    .NUM_REQ (NUM_REQ),
    .ID_W    (ID_W)
  ) u_rr (
    .req_i   (req_valid_i),
    .ptr_i   (rr_ptr),
    .gnt_o   (arb_gnt),
    .idx_o   (arb_idx),
    .any_o   (arb_any)
  );

  // one-hot of the locked owner
  always_comb begin
    own_oh        = '0;
    own_oh[owner] = 1'b1;
  end

  assign locked    = (state == LOCKED);
  assign grant     = locked ? own_oh : arb_gnt;
  assign sel_idx   = locked ? owner : arb_idx;
  assign sel_valid = (locked | arb_any) & req_valid_i[sel_idx];
  assign sel_last  = req_last_i[sel_idx];
  assign sel_d0    = req_data0_i[int'(sel_idx)*VW +: VW];
  assign sel_d1    = req_data1_i[int'(sel_idx)*VW +: VW];
  assign load_ok   = !mul_valid_o | mul_ready_i;
  assign accept    = sel_valid & load_ok;
  assign nxt_ptr   = ID_W'(wrap_inc(int'(sel_idx), NUM_REQ));

  assign req_ready_o = grant & {NUM_REQ{load_ok & rst_n_i}};

  // lock FSM, rr pointer and output beat register
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      state       <= IDLE;
      owner       <= '0;
      rr_ptr      <= '0;
      mul_valid_o <= 1'b0;
      mul_last_o  <= 1'b0;
      mul_id_o    <= '0;
      mul_data0_o <= '0;
      mul_data1_o <= '0;
    end else begin
      if (load_ok) begin
        mul_valid_o <= accept;
        mul_last_o  <= accept & sel_last;
        if (accept) begin
          mul_id_o    <= sel_idx;
          mul_data0_o <= sel_d0;
          mul_data1_o <= sel_d1;
        end
      end
      if (accept) begin
        unique case (state)
          IDLE: begin
            if (sel_last) begin
              rr_ptr <= nxt_ptr;
            end else begin
              state <= LOCKED;
              owner <= sel_idx;
            end
          end
          LOCKED: begin
            if (sel_last) begin
              state  <= IDLE;
              rr_ptr <= nxt_ptr;
            end
          end
          default: state <= IDLE;
        endcase
      end
    end
  end

`ifdef VEC_MUL_ARB_STATS_EN
  logic [STAT_W-1:0] pkt_cnt [NUM_REQ];
  logic [STAT_W-1:0] stall_cnt;

  // saturating completed-packet and stall counters
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      for (int r = 0; r < NUM_REQ; r++) pkt_cnt[r] <= '0;
      stall_cnt <= '0;
    end else begin
      for (int r = 0; r < NUM_REQ; r++) begin
        if (accept && sel_last &&
            sel_idx == ID_W'(r) && pkt_cnt[r] != '1)
          pkt_cnt[r] <= pkt_cnt[r] + 1'b1;
      end
      if (mul_valid_o && !mul_ready_i && stall_cnt != '1)
        stall_cnt <= stall_cnt + 1'b1;
    end
  end

  for (genvar r = 0; r < NUM_REQ; r++) begin : g_stat
    assign stat_pkts_o[r*STAT_W +: STAT_W] = pkt_cnt[r];
  end
  assign stat_stall_o = stall_cnt;
`endif

endmodule
